// File: rtl/ins_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and error codes for the instruction sequencer.
package ins_seq_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ISSUE = 8'h01;
  localparam logic [7:0] OP_WAIT  = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_END   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_GUARD,
    ST_WAIT_IDLE,
    ST_DELAY,
    ST_WAIT_DATA
  } state_t;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_BAD_OPCODE   = 2'd1;
  localparam logic [1:0] ERR_IDLE_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_DATA_TIMEOUT = 2'd3;

endpackage

// File: rtl/ins_sequencer_if.sv
// Instruction-FIFO and MUX-dispatch bus between the sequencer (master) and its neighbours (slave).
interface ins_sequencer_if;
  logic        ififo_empty;
  logic        ififo_rd;
  logic [31:0] ififo_data;
  logic        mux_en;
  logic [23:0] mux_ins;
  logic        mux_idle;
  logic        mux_data_ready;
  logic [15:0] mux_data;

  modport master (
    input  ififo_empty, ififo_data, mux_idle, mux_data_ready, mux_data,
    output ififo_rd, mux_en, mux_ins
  );

  modport slave (
    output ififo_empty, ififo_data, mux_idle, mux_data_ready, mux_data,
    input  ififo_rd, mux_en, mux_ins
  );
endinterface

// File: rtl/ins_sequencer_downcounter.sv
// 24-bit loadable downcounter with zero flag; shared by the guard and delay phases.
module seq_downcounter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] load_value,
  input  logic        dec,
  output logic        zero
);
  logic [23:0] count;

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count <= '0;
    else if (load)                count <= load_value;
    else if (dec && count != '0)  count <= count - 24'd1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/ins_sequencer.sv
// Fetches FWFT command words and issues timed MUX pulses/reads.
// Optional SEQ_TIMEOUT_EN adds a bounded wait on MUX idle and MUX data.
module ins_sequencer
  import ins_seq_pkg::*;
#(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        fpga_clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic        stop_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        result_valid_o,
  output logic [15:0] result_data_o,
  ins_sequencer_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 131071) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 17-bit wait counter");
  end

  localparam logic [23:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? 24'(GUARD_CYCLES - 1) : 24'd0;

  state_t      state, state_next;
  logic [31:0] ir;
  logic [7:0]  opcode;
  logic [23:0] arg;
  logic        rd_next, en_next, done_next, valid_next;
  logic        err_set, err_clr;
  logic [1:0]  err_code_set;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic [23:0] cnt_value;
  logic        wait_expired;

  assign opcode = ir[31:24];
  assign arg    = ir[23:0];

  seq_downcounter u_cnt (
    .clk        (fpga_clk_i),
    .rst_n      (reset_n_i),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

`ifdef SEQ_TIMEOUT_EN
  logic [16:0] wait_cnt;

  // Counts consecutive cycles spent in one of the two MUX wait states.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) wait_cnt <= '0;
    else if (state_next == state && (state == ST_WAIT_IDLE || state == ST_WAIT_DATA))
      wait_cnt <= wait_cnt + 17'd1;
    else
      wait_cnt <= '0;
  end

  assign wait_expired = (wait_cnt == 17'(TIMEOUT_CYCLES - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next   = state;
    rd_next      = 1'b0;
    en_next      = 1'b0;
    done_next    = 1'b0;
    valid_next   = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    err_code_set = ERR_NONE;
    cnt_load     = 1'b0;
    cnt_value    = '0;
    cnt_dec      = 1'b0;

    case (state)
      ST_IDLE: if (start_i) begin
        state_next = ST_FETCH;
        err_clr    = 1'b1;
      end
      ST_FETCH: if (!bus.ififo_empty) begin
        rd_next    = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: case (opcode)
        OP_NOP:   state_next = ST_FETCH;
        OP_ISSUE: begin
          en_next = 1'b1;
          if (GUARD_CYCLES == 0) state_next = ST_WAIT_IDLE;
          else begin
            cnt_load   = 1'b1;
            cnt_value  = GUARD_LOAD;
            state_next = ST_GUARD;
          end
        end
        OP_READ: begin
          en_next    = 1'b1;
          state_next = ST_WAIT_DATA;
        end
        OP_WAIT: begin
          if (arg == '0) state_next = ST_FETCH;
          else begin
            cnt_load   = 1'b1;
            cnt_value  = arg - 24'd1;
            state_next = ST_DELAY;
          end
        end
        OP_END: begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
        default: begin
          err_set      = 1'b1;
          err_code_set = ERR_BAD_OPCODE;
          state_next   = ST_IDLE;
        end
      endcase
      ST_GUARD: begin
        if (cnt_zero) state_next = ST_WAIT_IDLE;
        else          cnt_dec    = 1'b1;
      end
      ST_WAIT_IDLE: begin
        if (bus.mux_idle) state_next = ST_FETCH;
        else if (wait_expired) begin
          err_set      = 1'b1;
          err_code_set = ERR_IDLE_TIMEOUT;
          state_next   = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (cnt_zero) state_next = ST_FETCH;
        else          cnt_dec    = 1'b1;
      end
      ST_WAIT_DATA: begin
        if (bus.mux_data_ready) begin
          valid_next = 1'b1;
          state_next = ST_FETCH;
        end else if (wait_expired) begin
          err_set      = 1'b1;
          err_code_set = ERR_DATA_TIMEOUT;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (stop_i) begin
      state_next = ST_IDLE;
      rd_next    = 1'b0;
      en_next    = 1'b0;
      done_next  = 1'b0;
      valid_next = 1'b0;
      err_set    = 1'b0;
      err_clr    = 1'b0;
      cnt_load   = 1'b0;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= ST_IDLE;
      ir             <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      err_code_o     <= ERR_NONE;
      result_valid_o <= 1'b0;
      result_data_o  <= '0;
      bus.ififo_rd   <= 1'b0;
      bus.mux_en     <= 1'b0;
      bus.mux_ins    <= '0;
    end else begin
      state          <= state_next;
      busy_o         <= (state_next != ST_IDLE);
      done_o         <= done_next;
      result_valid_o <= valid_next;
      bus.ififo_rd   <= rd_next;
      bus.mux_en     <= en_next;
      if (rd_next)    ir            <= bus.ififo_data;
      if (en_next)    bus.mux_ins   <= arg;
      if (valid_next) result_data_o <= bus.mux_data;
      if (err_clr) begin
        err_o      <= 1'b0;
        err_code_o <= ERR_NONE;
      end else if (err_set) begin
        err_o      <= 1'b1;
        err_code_o <= err_code_set;
      end
    end
  end

endmodule
